// File: rtl/uart_rx_receiver.sv
// uart_rx_receiver: 8N1 UART receiver, OVERSAMPLE x baud clken, rdy/rdy_clr handshake.
// Define UART_RX_PARITY_EN for 8E1 frames with a parity_err output.
module uart_rx_receiver #(
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_50m,
  input  logic       rst,
  input  logic       rx,
  input  logic       clken,
  input  logic       rdy_clr,
  output logic [7:0] dout,
  output logic       rdy,
  output logic       frame_err,
  output logic       overrun,
  output logic       rx_busy
`ifdef UART_RX_PARITY_EN
  ,
  output logic       parity_err
`endif
);
  localparam int CW = $clog2(OVERSAMPLE + 1);
  localparam logic [CW-1:0] FULL = CW'(OVERSAMPLE);
  localparam logic [CW-1:0] HALF = CW'(OVERSAMPLE / 2);
  typedef enum logic [2:0] {
    IDLE, START, DATA, STOP, WAIT_HIGH
`ifdef UART_RX_PARITY_EN
    , PARITY
`endif
  } state_t;
`ifdef UART_RX_PARITY_EN
  localparam state_t AFTER_DATA = PARITY;
`else
  localparam state_t AFTER_DATA = STOP;
`endif
  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d, dout_q, dout_d;
  logic rdy_q, rdy_d, ferr_q, ferr_d, ovr_q, ovr_d;
  logic rx_s, at_full, done;
`ifdef UART_RX_PARITY_EN
  logic par_q, par_d, perr_q, perr_d;
`endif
  assign rx_s    = sync_q[SYNC_STAGES-1];
  assign cnt_inc = cnt_q + CW'(1);
  assign at_full = cnt_inc == FULL;
  always_ff @(posedge clk_50m or negedge rst) begin
    if (!rst) begin
      sync_q  <= '1;
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      dout_q  <= '0;
      rdy_q   <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], rx};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      dout_q  <= dout_d;
      rdy_q   <= rdy_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
`ifdef UART_RX_PARITY_EN
      par_q   <= par_d;
      perr_q  <= perr_d;
`endif
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    dout_d  = dout_q;
    rdy_d   = rdy_clr ? 1'b0 : rdy_q;
    ovr_d   = rdy_clr ? 1'b0 : ovr_q;
    ferr_d  = ferr_q;
    done    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
    perr_d  = perr_q;
`endif
    if (clken) begin
      case (state_q)
        IDLE: begin
          state_d = rx_s ? IDLE : START;
          cnt_d   = rx_s ? cnt_q : CW'(1);
        end
        START: begin
          cnt_d = (cnt_inc == HALF) ? '0 : cnt_inc;
          if (cnt_inc == HALF) state_d = rx_s ? IDLE : DATA;
        end
        DATA: begin
          cnt_d = at_full ? '0 : cnt_inc;
          if (at_full) begin
            shift_d = {rx_s, shift_q[7:1]};
            bit_d   = bit_q + 3'd1;
            state_d = (bit_q == 3'd7) ? AFTER_DATA : DATA;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          cnt_d = at_full ? '0 : cnt_inc;
          if (at_full) begin
            par_d   = rx_s;
            state_d = STOP;
          end
        end
`endif
        STOP: begin
          cnt_d = at_full ? '0 : cnt_inc;
          if (at_full) begin
            done    = rx_s;
            ferr_d  = ~rx_s;
            state_d = rx_s ? IDLE : WAIT_HIGH;
          end
        end
        WAIT_HIGH: state_d = rx_s ? IDLE : WAIT_HIGH;
        default:   state_d = IDLE;
      endcase
    end
    // a completing byte beats a same-cycle rdy_clr; overrun only if the old byte was unread
    if (done) begin
      dout_d = shift_q;
      rdy_d  = 1'b1;
      ovr_d  = ~rdy_clr & (ovr_q | rdy_q);
`ifdef UART_RX_PARITY_EN
      perr_d = ^{shift_q, par_q};
`endif
    end
  end
  assign dout      = dout_q;
  assign rdy       = rdy_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
  assign rx_busy   = state_q != IDLE;
`ifdef UART_RX_PARITY_EN
  assign parity_err = perr_q;
`endif
endmodule

// File: doc/uart_rx_receiver.md
Name: uart_rx_receiver

Overview:
UART receive stage that consumes the serial line driven by the team's transmitter block (8N1, LSB first, idle high). Oversamples the line on a 16x-baud clken strobe, recovers each frame, and presents the byte with a ready/clear handshake. It sits between the pad or loopback and the host-side consumer, and shares the clk_50m domain and baud-tick generator with the transmitter.

Parameters:
OVERSAMPLE, 16, clken ticks per bit period; even value, 4 to 16.
SYNC_STAGES, 2, flops in the rx input synchronizer; minimum 2.

Ports:
clk_50m  input  1  system clock, 50 MHz.
rst  input  1  asynchronous, active-low reset.
rx  input  1  serial line, asynchronous to clk_50m, idle high.
clken  input  1  one-cycle strobe at OVERSAMPLE x baud.
rdy_clr  input  1  consumer acknowledge; clears rdy and overrun.
dout  output  8  last correctly framed byte.
rdy  output  1  dout holds an unread byte.
frame_err  output  1  last frame had stop bit = 0 (sticky until next good frame).
overrun  output  1  a byte completed while rdy=1 (sticky until rdy_clr).
rx_busy  output  1  high while state != IDLE.

Behaviour:
- Clock and reset: one clock, clk_50m. Reset rst is asynchronous, active-low. The rx synchronizer chain resets to all-1s.
- Reset values: dout=8'h00, rdy=0, frame_err=0, overrun=0, rx_busy=0. The FSM resets to IDLE with the sample counter and bit counter at 0.
- A reset asserted mid-frame aborts the frame. No rdy or error flag is produced for it.
- All sampling uses rx_s, the synchronizer output. State changes occur only on cycles with clken=1.
- rdy_clr acts on any cycle, independent of clken.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH, plus PARITY when the optional feature is compiled in.
- IDLE: on clken with rx_s=0, go to START with sample counter = 1.
- START: counter increments on each clken. When counter reaches OVERSAMPLE/2:
  - rx_s=0: clear the counter and go to DATA.
  - rx_s=1: treat as a glitch and return to IDLE.
- DATA: when counter reaches OVERSAMPLE (the bit centre), shift rx_s into shift_reg[7] (right shift, LSB first) and clear the counter. After the 8th bit, go to STOP (or PARITY).
- STOP: when counter reaches OVERSAMPLE, sample rx_s.
  - rx_s=1: dout <= shift_reg, rdy <= 1, frame_err <= 0. Return to IDLE.
  - rx_s=0: frame_err <= 1. dout and rdy are unchanged. Go to WAIT_HIGH.
- WAIT_HIGH: stay until a clken with rx_s=1, then go to IDLE. This prevents a break condition from retriggering reception.
- Latency: rdy rises on the clk_50m edge of the mid-stop-bit clken. Approximately 9.5 bit times (plus SYNC_STAGES cycles) after the start falling edge.
- Overrun: if a good frame completes while rdy=1 and rdy_clr=0, set overrun=1. dout is overwritten with the new byte and rdy stays 1.
- Simultaneous completion and rdy_clr: the new byte wins. rdy stays 1 and overrun is not set; an overrun already set is cleared.
- rdy_clr with no completion in the same cycle: rdy <= 0, overrun <= 0.
- Back-to-back frames: IDLE re-arms one clken after the stop sample. A start edge arriving half a bit after the stop centre is detected.

Optional Feature:
Macro UART_RX_PARITY_EN.
- Defined: the frame is 8E1. A PARITY state between DATA and STOP samples the parity bit at bit centre.
  - Output parity_err (1 bit) is added; it resets to 0.
  - parity_err is set when XOR(data, parity bit) != 0. The byte is still delivered (rdy=1) and parity_err qualifies it.
  - parity_err is cleared on the next good-parity frame.
- Not defined: no PARITY state and no parity_err port. The frame is 8N1 exactly as above.

Test Plan:
- Send 0xA5 (8N1, 16 clken/bit) -> rdy=1 about 152 clken after the start edge, dout=0xA5, frame_err=0, overrun=0. Assert rdy_clr -> rdy=0 the next cycle.
- Send 0x00 then 0xFF back-to-back, reading each with rdy_clr -> dout=0x00, then 0xFF. Two rdy pulses, no errors.
- rx low for 4 clken then high -> FSM returns to IDLE, rx_busy drops, rdy stays 0.
- Frame 0x3C with stop bit driven 0, rx held low 3 bit times, then valid 0x81 -> frame_err=1 and no rdy for 0x3C. No spurious frame during the low period. 0x81 then gives rdy=1, dout=0x81, frame_err=0.
- Receive 0x11 and 0x22 without rdy_clr -> dout=0x22, rdy=1, overrun=1. A rdy_clr coincident with 0x33 completing -> rdy=1, overrun=0, dout=0x33.
- Assert rst during bit 4 of 0x5A, release, then send 0xC3 -> all outputs at reset values after rst, then dout=0xC3. With UART_RX_PARITY_EN, 0xC3 sent with parity=1 -> parity_err=1, rdy=1.
